// File: rtl/alarm_ring_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_ring_ctrl
// Sits downstream of the alarm clock core. It turns the core's Alarm level
// into a 1 s on / 1 s off buzzer pattern and handles snooze, ring timeout and
// dismissal. After every dismissal it holds the core's STOP_al input high
// through a lockout window, so the alarm minute that still matches cannot
// fire the alarm again.
//
// Ports
//   clk_1s        in   1 s tick clock, rising edge
//   reset         in   asynchronous, active-high
//   alarm_in      in   Alarm level from the clock core
//   snooze_btn    in   snooze request (debounced upstream)
//   stop_btn      in   dismiss request (debounced upstream)
//   buzzer        out  buzzer drive, toggles every tick while ringing
//   stop_al       out  to core STOP_al; high only in LOCKOUT
//   ringing       out  state == RING
//   snoozing      out  state == SNOOZE
//   snooze_left   out  remaining snooze ticks; 0 outside SNOOZE
//   snooze_count  out  snoozes used in the current alarm event
//   timed_out     out  sticky: last event ended by ring timeout
//   dbg_state     out  current FSM state (0 IDLE, 1 RING, 2 SNOOZE, 3 LOCKOUT)
//
// Button handshake: snooze_btn and stop_btn are plain levels sampled on each
// clk_1s edge. There is no ready/acknowledge path. A press counts only if it
// is high at an edge where the current state acts on that button.
// ---------------------------------------------------------------------------
module alarm_ring_ctrl #(
   parameter int SNOOZE_SEC       = 300,
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int LOCK_SEC         = 60,
   parameter int MAX_SNOOZE       = 3,
   parameter int CNT_W            = 9
) (
   input  logic             clk_1s,
   input  logic             reset,
   input  logic             alarm_in,
   input  logic             snooze_btn,
   input  logic             stop_btn,
   output logic             buzzer,
   output logic             stop_al,
   output logic             ringing,
   output logic             snoozing,
   output logic [CNT_W-1:0] snooze_left,
   output logic [1:0]       snooze_count,
   output logic             timed_out,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RING    = 2'd1,
      S_SNOOZE  = 2'd2,
      S_LOCKOUT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TIMEOUT_SEC - 1);
   localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SEC);
   localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_SEC);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [1:0]       SNZ_MAX   = 2'(MAX_SNOOZE);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [1:0]       snooze_count_q, snooze_count_d;
   logic             timed_out_q, timed_out_d;
   logic             buzzer_q, buzzer_d;
   logic             stop_al_q, stop_al_d;
   logic             ringing_q, ringing_d;
   logic             snoozing_q, snoozing_d;
   logic [CNT_W-1:0] snooze_left_q, snooze_left_d;

   always_comb begin
      state_d        = state_q;
      ring_cnt_d     = ring_cnt_q;
      timer_d        = timer_q;
      snooze_count_d = snooze_count_q;
      timed_out_d    = timed_out_q;

      case (state_q)
         S_IDLE: begin
            if (alarm_in) begin
               state_d        = S_RING;
               ring_cnt_d     = '0;
               snooze_count_d = 2'd0;
               timed_out_d    = 1'b0;
            end
         end
         S_RING: begin
            // Priority order: stop first, then timeout, then snooze.
            if (stop_btn) begin
               state_d = S_LOCKOUT;
               timer_d = LOCK_LD;
            end else if (ring_cnt_q == RING_LAST) begin
               state_d     = S_LOCKOUT;
               timer_d     = LOCK_LD;
               timed_out_d = 1'b1;
            end else if (snooze_btn && (snooze_count_q < SNZ_MAX)) begin
               state_d        = S_SNOOZE;
               timer_d        = SNOOZE_LD;
               snooze_count_d = snooze_count_q + 2'd1;
            end else begin
               ring_cnt_d = ring_cnt_q + ONE;
            end
         end
         S_SNOOZE: begin
            if (stop_btn) begin
               state_d = S_LOCKOUT;
               timer_d = LOCK_LD;
            end else if (timer_q == ONE) begin
               state_d    = S_RING;
               ring_cnt_d = '0;
            end else begin
               timer_d = timer_q - ONE;
            end
         end
         default: begin  // S_LOCKOUT
            if (timer_q == ONE) begin
               state_d = S_IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q - ONE;
            end
         end
      endcase

      // The outputs are computed from the next state so that every output
      // changes on the same edge as the state it reports.
      if (state_d == S_RING) begin
         buzzer_d = (state_q == S_RING) ? ~buzzer_q : 1'b1;
      end else begin
         buzzer_d = 1'b0;
      end
      stop_al_d     = (state_d == S_LOCKOUT);
      ringing_d     = (state_d == S_RING);
      snoozing_d    = (state_d == S_SNOOZE);
      snooze_left_d = (state_d == S_SNOOZE) ? timer_d : '0;
   end

   always_ff @(posedge clk_1s or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         ring_cnt_q     <= '0;
         timer_q        <= '0;
         snooze_count_q <= 2'd0;
         timed_out_q    <= 1'b0;
         buzzer_q       <= 1'b0;
         stop_al_q      <= 1'b0;
         ringing_q      <= 1'b0;
         snoozing_q     <= 1'b0;
         snooze_left_q  <= '0;
      end else begin
         state_q        <= state_d;
         ring_cnt_q     <= ring_cnt_d;
         timer_q        <= timer_d;
         snooze_count_q <= snooze_count_d;
         timed_out_q    <= timed_out_d;
         buzzer_q       <= buzzer_d;
         stop_al_q      <= stop_al_d;
         ringing_q      <= ringing_d;
         snoozing_q     <= snoozing_d;
         snooze_left_q  <= snooze_left_d;
      end
   end

   assign buzzer       = buzzer_q;
   assign stop_al      = stop_al_q;
   assign ringing      = ringing_q;
   assign snoozing     = snoozing_q;
   assign snooze_left  = snooze_left_q;
   assign snooze_count = snooze_count_q;
   assign timed_out    = timed_out_q;
   assign dbg_state    = state_q;

endmodule
